// File: rtl/int_ctrl.sv
// Interrupt controller in front of fetch: synchronises and edge-detects sources,
// holds them pending, masks and prioritises them, and issues one vectored interrupt at a time.
module int_ctrl #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0004,
  parameter int unsigned VEC_STRIDE  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               fire_block,
  input  logic               rti,
  input  logic               rsi,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [31:0]        cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               int_fire,
  output logic [31:0]        int_vector,
  output logic               int_busy
);

  localparam int unsigned ID_W   = 5;
  localparam int unsigned SYNC_W = SYNC_STAGES * NUM_SRC;

  localparam logic [1:0] A_ENABLE = 2'd0;
  localparam logic [1:0] A_PEND   = 2'd1;
  localparam logic [1:0] A_CAUSE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FIRE    = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t              state_q;
  logic [SYNC_W-1:0]   sync_q;
  logic [NUM_SRC-1:0]  sync_last;
  logic [NUM_SRC-1:0]  hist_q;
  logic [NUM_SRC-1:0]  irq_edge;
  logic [NUM_SRC-1:0]  pending_q;
  logic [NUM_SRC-1:0]  enable_q;
  logic [NUM_SRC-1:0]  eligible;
  logic [NUM_SRC-1:0]  win_oh;
  logic [NUM_SRC-1:0]  pend_clr;
  logic [NUM_SRC-1:0]  pend_d;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     cause_q;
  logic [31:0]         win_vector;
  logic                fire_go;
  logic                unused_wdata;

  assign unused_wdata = ^cfg_wdata;

  // Synchroniser shift chain (stage 0 in the low bits) plus one history stage for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q <= SYNC_W'({sync_q, irq_in});
      hist_q <= sync_last;
    end
  end

  assign sync_last = sync_q[SYNC_W-1 -: NUM_SRC];
  assign irq_edge  = sync_last & ~hist_q;

  // Fixed priority: isolate the lowest set eligible bit, then encode it
  always_comb begin
    eligible = pending_q & enable_q;
    win_oh   = eligible & (~eligible + NUM_SRC'(1));
    win_id   = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (win_oh == (NUM_SRC'(1) << i)) win_id = ID_W'(i);
    end
  end

  assign fire_go    = (state_q == S_IDLE) && (eligible != '0) && !fire_block;
  assign win_vector = VEC_BASE + 32'(win_id) * 32'(VEC_STRIDE);

  // A new edge wins over a same-cycle clear from firing or software
  always_comb begin
    pend_clr = '0;
    if (fire_go)                       pend_clr = pend_clr | win_oh;
    if (cfg_we && cfg_addr == A_PEND)  pend_clr = pend_clr | cfg_wdata[NUM_SRC-1:0];
    pend_d = (pending_q & ~pend_clr) | irq_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      enable_q  <= '1;
    end else begin
      pending_q <= pend_d;
      if (cfg_we && cfg_addr == A_ENABLE) enable_q <= cfg_wdata[NUM_SRC-1:0];
    end
  end

  // Service FSM with registered fire/busy/vector outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cause_q    <= '0;
      int_fire   <= 1'b0;
      int_busy   <= 1'b0;
      int_vector <= VEC_BASE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fire_go) begin
            state_q    <= S_FIRE;
            cause_q    <= win_id;
            int_fire   <= 1'b1;
            int_busy   <= 1'b1;
            int_vector <= win_vector;
          end
        end
        S_FIRE: begin
          state_q  <= S_SERVICE;
          int_fire <= 1'b0;
        end
        S_SERVICE: begin
          if (rti || rsi) begin
            state_q  <= S_IDLE;
            int_busy <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          int_fire <= 1'b0;
          int_busy <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      A_ENABLE: cfg_rdata = 32'(enable_q);
      A_PEND:   cfg_rdata = 32'(pending_q);
      A_CAUSE:  cfg_rdata = {int_busy, 26'b0, cause_q};
      default:  cfg_rdata = '0;
    endcase
  end

endmodule
